// File: rtl/serial_subtractor16_pkg.sv
// Shared types and sizing for the slice-serial 16-bit subtractor.
package serial_subtractor16_pkg;

  localparam int unsigned DataWidth  = 16;
  localparam int unsigned SliceWidth = 4;
  localparam int unsigned NumSlices  = 4;
  localparam int unsigned CntWidth   = $clog2(NumSlices);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/sub4_slice.sv
// Combinational 4-bit subtractor with borrow-in and borrow-out.
module sub4_slice
  import serial_subtractor16_pkg::*;
(
  input  logic [SliceWidth-1:0] a_i,
  input  logic [SliceWidth-1:0] b_i,
  input  logic                  bin_i,
  output logic [SliceWidth-1:0] diff_o,
  output logic                  bout_o
);

  logic [SliceWidth:0] wide;

  // The extra top bit goes to 1 exactly when the slice underflows.
  always_comb begin
    wide = {1'b0, a_i} - {1'b0, b_i} - {{SliceWidth{1'b0}}, bin_i};
  end

  assign diff_o = wide[SliceWidth-1:0];
  assign bout_o = wide[SliceWidth];

endmodule

// File: rtl/serial_subtractor16.sv
// 16-bit subtractor computing A - B - Bin one 4-bit slice per cycle, with result flags.
module serial_subtractor16
  import serial_subtractor16_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DataWidth-1:0] A,
  input  logic [DataWidth-1:0] B,
  input  logic                 Bin,
  output logic                 busy,
  output logic                 done,
  output logic [DataWidth-1:0] Out,
  output logic                 Cflag,
  output logic                 Zero,
  output logic                 Sign,
  output logic                 Parity,
  output logic                 Overflow
);

  localparam int unsigned AccWidth = DataWidth - SliceWidth;
  localparam logic [CntWidth-1:0] LastSlice = CntWidth'(NumSlices - 1);

  state_e                state_q;
  logic [CntWidth-1:0]   cnt_q;
  logic [DataWidth-1:0]  a_q, b_q;
  logic                  borrow_q;
  logic [AccWidth-1:0]   acc_q;
  logic [DataWidth-1:0]  out_q;
  logic                  cflag_q, zero_q, sign_q, parity_q, overflow_q;

  logic [SliceWidth-1:0] slice_a, slice_b, slice_diff;
  logic                  slice_bout;
  logic [DataWidth-1:0]  result;

  always_comb begin
    slice_a = a_q[cnt_q * SliceWidth +: SliceWidth];
    slice_b = b_q[cnt_q * SliceWidth +: SliceWidth];
    // Completed slices shift in from the top, so the final slice lands above them.
    result  = {slice_diff, acc_q};
  end

  sub4_slice u_slice (
    .a_i    (slice_a),
    .b_i    (slice_b),
    .bin_i  (borrow_q),
    .diff_o (slice_diff),
    .bout_o (slice_bout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      borrow_q   <= 1'b0;
      acc_q      <= '0;
      out_q      <= '0;
      cflag_q    <= 1'b0;
      zero_q     <= 1'b0;
      sign_q     <= 1'b0;
      parity_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q  <= StRun;
            a_q      <= A;
            b_q      <= B;
            borrow_q <= Bin;
            cnt_q    <= '0;
          end else begin
            state_q  <= StIdle;
          end
        end
        StRun: begin
          acc_q    <= {slice_diff, acc_q[AccWidth-1:SliceWidth]};
          borrow_q <= slice_bout;
          if (cnt_q == LastSlice) begin
            state_q    <= StDone;
            out_q      <= result;
            cflag_q    <= slice_bout;
            zero_q     <= (result == '0);
            sign_q     <= result[DataWidth-1];
            parity_q   <= ~^result;
            overflow_q <= (a_q[DataWidth-1] != b_q[DataWidth-1]) &&
                          (result[DataWidth-1] != a_q[DataWidth-1]);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy     = (state_q == StRun);
  assign done     = (state_q == StDone);
  assign Out      = out_q;
  assign Cflag    = cflag_q;
  assign Zero     = zero_q;
  assign Sign     = sign_q;
  assign Parity   = parity_q;
  assign Overflow = overflow_q;

endmodule

// File: doc/serial_subtractor16.md
SERIAL_SUBTRACTOR16 -- requirements
Module: serial_subtractor16

Interface
REQ-001 Parameters: none; datapath fixed at 16 bits, processed as four 4-bit slices.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; sampled on rising edge of clk.
REQ-005 A  input  16  minuend; sampled with start.
REQ-006 B  input  16  subtrahend; sampled with start.
REQ-007 Bin  input  1  borrow-in; sampled with start.
REQ-008 busy  output  1  high while subtraction in progress.
REQ-009 done  output  1  one-cycle pulse; result and flags valid.
REQ-010 Out  output  16  difference A - B - Bin, modulo 2^16.
REQ-011 Cflag  output  1  borrow-out (1 when A < B + Bin, unsigned).
REQ-012 Zero  output  1  1 when Out == 16'h0000.
REQ-013 Sign  output  1  equals Out[15].
REQ-014 Parity  output  1  1 when Out has an even number of 1 bits.
REQ-015 Overflow  output  1  signed overflow: A[15] != B[15] and Out[15] != A[15].

Function
REQ-016 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-017 IDLE or DONE with start=1: latch A, B, Bin, clear slice counter, go RUN.
REQ-018 DONE with start=0: go IDLE; IDLE with start=0: stay IDLE.
REQ-019 RUN: each cycle computes one slice, LSB slice first: diff = A[4i+3:4i] - B[4i+3:4i] - borrow, borrow initialised to latched Bin.
REQ-020 RUN: slice counter 0..3; after slice 3 go DONE; counter wraps to 0 only via new start.
REQ-021 Latency: start sampled at edge k -> slices at edges k+1..k+4 -> done=1 in cycle after edge k+4.
REQ-022 busy = 1 exactly in RUN; done = 1 exactly in DONE.
REQ-023 start while RUN ignored; latched operands unchanged; no queuing.
REQ-024 Out and all flags updated only on the edge entering DONE; held stable until next DONE entry.
REQ-025 Flags derived from full 16-bit result and final borrow, not per slice.
REQ-026 Input changes on A/B/Bin outside a start-accepting edge have no effect.

Reset
REQ-027 rst_n=0 asynchronously forces IDLE, busy=0, done=0, Out=16'h0000, Cflag=0, Zero=0, Sign=0, Parity=0, Overflow=0, counter=0.
REQ-028 Reset mid-RUN aborts the operation; no done pulse for it; first start after rst_n release accepted normally.

Structure
REQ-029 Shared package holds: state encoding (IDLE, RUN, DONE), data width 16, slice width 4, slice count 4.
REQ-030 One sub-module, sub4_slice: combinational 4-bit subtract with borrow-in/borrow-out; instantiated once, reused each RUN cycle.
REQ-031 Flag generation lives in serial_subtractor16, not in sub4_slice.

Verification
REQ-032 A=16'hA6C3, B=16'hA22E, Bin=1 -> Out=16'h0494, Cflag=0, Zero=0, Sign=0, Parity=1, Overflow=0; done 5 cycles after start edge.
REQ-033 A=16'h16C3, B=16'hA62E, Bin=0 -> Out=16'h7095, Cflag=1, Zero=0, Sign=0, Parity=0, Overflow=0.
REQ-034 A=16'h8000, B=16'h0001, Bin=0 -> Out=16'h7FFF, Cflag=0, Sign=0, Parity=0, Overflow=1.
REQ-035 A=16'h0000, B=16'h0000, Bin=0 -> Out=16'h0000, Zero=1, Parity=1, Cflag=0, Sign=0, Overflow=0.
REQ-036 Start with A=16'h36C3, B=16'h022E, then start with other operands during RUN -> second ignored; Out=16'h3495, single done pulse.
REQ-037 rst_n low for one cycle during RUN slice 2 -> all outputs reset values, no done; next start completes normally.
